izigzag_reorder: RTL and testbench

//   Inverse zig-zag reorder for the JPEG decode path, the mirror of the encoder's fdct_zigzag stage.

---
 rtl/jpeg_dec_pkg.sv | 27 ++
 rtl/izz_bank_ram.sv | 33 +++
 rtl/izigzag_reorder.sv | 129 ++++++++++++
 tb/tb_izigzag_reorder.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_dec_pkg.sv
// Shared JPEG decode-path definitions: block size, coefficient index type
// and the zig-zag-position to raster-position table.
package jpeg_dec_pkg;

  localparam int BLK_SZ = 64;

  typedef logic [5:0] coef_idx_t;

  // ZZ2RAS[k] is the raster index (row*8+col) of zig-zag position k.
  // It is the inverse of the encoder's raster-to-zig-zag table.
  localparam coef_idx_t ZZ2RAS [BLK_SZ] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Swap row and column fields of a 6-bit block index.
  function automatic coef_idx_t transpose_idx(input coef_idx_t idx);
    return {idx[2:0], idx[5:3]};
  endfunction

endpackage

// File: rtl/izz_bank_ram.sv
// Two-bank 64-entry coefficient store: one write port, one registered read
// port. Address bit 6 selects the bank. The read register is reset so the
// block output reads zero out of reset.
module izz_bank_ram #(
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [6:0]               waddr_i,
  input  logic signed [DATA_W-1:0] wdata_i,
  input  logic                     re_i,
  input  logic [6:0]               raddr_i,
  output logic signed [DATA_W-1:0] rdata_o
);

  logic signed [DATA_W-1:0] mem_q [128];
  logic signed [DATA_W-1:0] rdata_q;

  // Storage array write; contents are don't-care until a block is written.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read; holds its value while no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/izigzag_reorder.sv
// Inverse zig-zag reorder, ping-pong buffered, 1 coefficient/cycle.
// Zig-zag ordered coefficients are scattered into a bank at their raster
// address; a full bank is drained sequentially through a 1-cycle read.
// Build option IZZ_TRANSPOSE_EN: drain in column-major order instead of
// row-major, with identical timing and handshake.
module izigzag_reorder
  import jpeg_dec_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int NBANK  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_sob,
  output logic                     out_eob
);

  if (NBANK != 2) begin : g_nbank_check
    $error("izigzag_reorder: NBANK must be 2");
  end

  coef_idx_t  wr_cnt_q, wr_cnt_d;
  coef_idx_t  rd_cnt_q, rd_cnt_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] full_q, full_d;
  logic       ov_q, ov_d;
  logic       sob_q, sob_d;
  logic       eob_q, eob_d;

  logic       wr_fire;
  logic       rd_fire;
  coef_idx_t  rd_idx;

  assign in_ready = !full_q[wr_bank_q];
  assign wr_fire  = in_valid && in_ready;
  // Fetch when a block is ready and the output register is free or draining.
  assign rd_fire  = full_q[rd_bank_q] && (!ov_q || out_ready);

`ifdef IZZ_TRANSPOSE_EN
  assign rd_idx = transpose_idx(rd_cnt_q);
`else
  assign rd_idx = rd_cnt_q;
`endif

  // Next-state for counters, bank pointers, full flags and output flags.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    ov_d      = ov_q;
    sob_d     = sob_q;
    eob_d     = eob_q;

    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 6'd1;
      if (wr_cnt_q == 6'd63) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end

    // The drained bank is never the bank being written, so a fill and a
    // drain-complete in the same cycle touch different flags.
    if (rd_fire) begin
      rd_cnt_d = rd_cnt_q + 6'd1;
      ov_d     = 1'b1;
      sob_d    = (rd_cnt_q == 6'd0);
      eob_d    = (rd_cnt_q == 6'd63);
      if (rd_cnt_q == 6'd63) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end else if (ov_q && out_ready) begin
      ov_d  = 1'b0;
      sob_d = 1'b0;
      eob_d = 1'b0;
    end
  end

  // Control state register; reset discards all buffered and partial blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      ov_q      <= 1'b0;
      sob_q     <= 1'b0;
      eob_q     <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      ov_q      <= ov_d;
      sob_q     <= sob_d;
      eob_q     <= eob_d;
    end
  end

  izz_bank_ram #(
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_fire),
    .waddr_i ({wr_bank_q, ZZ2RAS[wr_cnt_q]}),
    .wdata_i (in_data),
    .re_i    (rd_fire),
    .raddr_i ({rd_bank_q, rd_idx}),
    .rdata_o (out_data)
  );

  assign out_valid = ov_q;
  assign out_sob   = sob_q;
  assign out_eob   = eob_q;

endmodule

// File: tb/tb_izigzag_reorder.sv
// Bench for izigzag_reorder: scoreboard of expected outputs built from an
// independently generated zig-zag walk, plus scenario table and hand-written
// corner sequences (latency, back-pressure, reset mid-block).
module tb_izigzag_reorder;

  localparam int DATA_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sob;
  logic              out_eob;

  always #5 clk = ~clk;

  izigzag_reorder #(.DATA_W(DATA_W), .NBANK(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sob   (out_sob),
    .out_eob   (out_eob)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sob;
    logic              eob;
  } exp_t;

  typedef struct {
    int nblk;
    int gap_pct;
    int rdy_mode;
    int data_mode;
    int exp_out;
  } scen_t;

  int                total = 0;
  int                bad   = 0;
  int                zz [64];
  logic [DATA_W-1:0] blk [64];
  exp_t              exp_q [$];
  exp_t              e;
  int                wk = 0;
  int                cyc = 0;
  int                n_out = 0;
  int                last_acc_cyc = 0;
  int                first_ov_cyc = 0;
  bit                ov_seen = 0;
  bit                stall_prev = 0;
  logic [DATA_W+1:0] held;
  bit                w2 = 0;
  int                n2_start = 0;
  int                rdy_low2 = 0;
  int                gaps2 = 0;
  bit                w3 = 0;
  bit                prev_inrdy = 1;
  bit                eob3_seen = 0;
  int                rdy_mode = 0;
  int                rdy_fixed = 1;
  int                got [64];
  int                got_n = 64;
  int                ov_after_rst = 0;
  bit                w5 = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Emission order index -> raster index.
  function automatic int emit_addr(input int r);
`ifdef IZZ_TRANSPOSE_EN
    return (r % 8) * 8 + r / 8;
`else
    return r;
`endif
  endfunction

  // Zig-zag walk over the anti-diagonals of the 8x8 block.
  function automatic void build_zz();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int row = hi; row >= lo; row--) begin zz[n] = row * 8 + (s - row); n++; end
      end else begin
        for (int row = lo; row <= hi; row++) begin zz[n] = row * 8 + (s - row); n++; end
      end
    end
  endfunction

  // out_ready driver: fixed level or 50% random, changed just after the edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'(rdy_fixed);
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      wk = 0;
      exp_q.delete();
      stall_prev = 0;
    end else begin
      cyc++;
      if (stall_prev)
        check("stall_hold", int'({out_valid, out_sob, out_eob, out_data}), int'({1'b1, held}));
      if (in_valid && in_ready) begin
        blk[zz[wk]] = in_data;
        if (wk == 63) begin
          last_acc_cyc = cyc;
          for (int r = 0; r < 64; r++) begin
            e.data = blk[emit_addr(r)];
            e.sob  = (r == 0);
            e.eob  = (r == 63);
            exp_q.push_back(e);
          end
        end
        wk = (wk + 1) % 64;
      end
      if (out_valid && !ov_seen) begin
        ov_seen = 1;
        first_ov_cyc = cyc;
      end
      if (w5 && out_valid) ov_after_rst++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_word", int'({out_sob, out_eob, out_data}), int'({e.sob, e.eob, e.data}));
        end
        if (got_n < 64) begin got[got_n] = int'(out_data); got_n++; end
        n_out++;
      end
      stall_prev = out_valid && !out_ready;
      held = {out_sob, out_eob, out_data};
      if (w2) begin
        if (!in_ready) rdy_low2++;
        if (!out_valid && n_out > n2_start && n_out < n2_start + 256) gaps2++;
      end
      if (w3) begin
        if (out_valid && out_eob && !eob3_seen) begin
          eob3_seen = 1;
          check("inrdy_after_eob_fetch", int'(in_ready), 1);
          check("inrdy_before_eob_fetch", int'(prev_inrdy), 0);
        end
        prev_inrdy = in_ready;
      end
    end
  end

  // Send n coefficients; data mode 0: k+base, 1: random, 2: ZZ2RAS[k].
  task automatic send(input int n, input int mode, input int base, input int gap_pct);
    for (int k = 0; k < n; k++) begin
      bit acc;
      int t;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      case (mode)
        0:       in_data = DATA_W'(k + base);
        1:       in_data = DATA_W'($urandom);
        default: in_data = DATA_W'(zz[k]);
      endcase
      t = 0;
      forever begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        if (acc) break;
        t++;
        if (t > 5000) begin check("in_accept_timeout", 0, 1); break; end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 20000) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) begin @(posedge clk); #1; end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_sob_eob", int'({out_sob, out_eob}), 0);
    rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    scen_t scen [4];
    int    n0;

    build_zz();
    scen[0] = '{nblk: 20, gap_pct: 30, rdy_mode: 1, data_mode: 1, exp_out: 1280};
    scen[1] = '{nblk: 3,  gap_pct: 0,  rdy_mode: 1, data_mode: 0, exp_out: 192};
    scen[2] = '{nblk: 2,  gap_pct: 50, rdy_mode: 0, data_mode: 1, exp_out: 128};
    scen[3] = '{nblk: 1,  gap_pct: 0,  rdy_mode: 0, data_mode: 2, exp_out: 64};

    in_valid = 1'b0;
    in_data  = '0;
    rst      = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Single block, in_data = zig-zag index: latency and raster mapping.
    ov_seen = 0;
    got_n = 0;
    send(64, 0, 0, 0);
    drain();
    check("first_out_latency", first_ov_cyc - last_acc_cyc, 2);
    check("blk1_count", n_out, 64);
`ifndef IZZ_TRANSPOSE_EN
    check("ras0", got[0], 0);
    check("ras1", got[1], 1);
    check("ras2", got[2], 5);
    check("ras8", got[8], 2);
    check("ras63", got[63], 63);
`endif

    // Four back-to-back blocks with out_ready high.
    n2_start = n_out;
    rdy_low2 = 0;
    gaps2 = 0;
    w2 = 1;
    for (int b = 0; b < 4; b++) send(64, 0, 64 * b, 0);
    drain();
    w2 = 0;
    check("b2b_in_ready_drops", rdy_low2, 0);
    check("b2b_output_gaps", gaps2, 0);
    check("b2b_count", n_out - n2_start, 256);

    // Both banks filled while the output is stalled.
    rdy_fixed = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    eob3_seen = 0;
    prev_inrdy = 1;
    w3 = 1;
    send(64, 1, 0, 0);
    send(64, 1, 0, 0);
    @(negedge clk);
    check("in_ready_both_full", int'(in_ready), 0);
    repeat (5) @(posedge clk);
    #1;
    check("in_ready_still_low", int'(in_ready), 0);
    rdy_fixed = 1;
    drain();
    w3 = 0;
    check("eob_seen_after_stall", int'(eob3_seen), 1);

    // Scenario table.
    for (int i = 0; i < 4; i++) begin
      rdy_mode  = scen[i].rdy_mode;
      rdy_fixed = 1;
      n0 = n_out;
      for (int b = 0; b < scen[i].nblk; b++)
        send(64, scen[i].data_mode, 64 * b, scen[i].gap_pct);
      drain();
      rdy_mode = 0;
      check($sformatf("scen%0d_count", i), n_out - n0, scen[i].exp_out);
    end

    // Identity data: emission order exposed directly.
    got_n = 0;
    send(64, 2, 0, 0);
    drain();
`ifdef IZZ_TRANSPOSE_EN
    check("order1", got[1], 8);
    check("order8", got[8], 1);
    check("order9", got[9], 9);
    check("order63", got[63], 63);
`else
    check("order1", got[1], 1);
    check("order8", got[8], 8);
    check("order63", got[63], 63);
`endif

    // Reset after 30 coefficients; partial block must vanish.
    send(30, 1, 0, 0);
    do_reset();
    ov_after_rst = 0;
    w5 = 1;
    repeat (10) begin @(posedge clk); #1; end
    w5 = 0;
    check("no_out_after_rst", ov_after_rst, 0);
    n0 = n_out;
    send(64, 0, 100, 0);
    drain();
    check("clean_blk_count", n_out - n0, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
